// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Program sequencer on the requesting side of a combinational instruction ROM.
// It drives the ROM address from the PC, registers the returned 28-bit
// instruction, resolves JMP and timed NOP locally, and applies BLE redirects
// that the datapath reports back.
//
// Build option:
//   FETCH_NOP_DELAY_EN - when defined, a NOP whose 24-bit immediate N is
//                        non-zero stalls issue for exactly N bubble cycles
//                        (DELAY state). When undefined, every NOP issues in
//                        one cycle, the DELAY state/counter are not built and
//                        oDelayBusy is tied to 0.
//
// Ports:
//   Clock          in   rising-edge clock
//   Reset          in   asynchronous active-low reset
//   oAddress       out  16-bit ROM address (the PC register)
//   iInstruction   in   28-bit combinational ROM data for oAddress
//   oInstruction   out  registered instruction to the datapath
//   oValid         out  oInstruction is to be executed this cycle
//   oInstrAddr     out  address oInstruction was fetched from
//   iStall         in   datapath busy; freeze fetch
//   iBranchTaken   in   BLE currently in oInstruction evaluated as taken
//   iBranchTarget  in   8-bit BLE target (zero-extended into the PC)
//   oDelayBusy     out  timed-NOP countdown in progress
//
// Handshake: the datapath executes oInstruction in every cycle where
// oValid=1. iStall=1 freezes PC/oInstruction/oValid/oInstrAddr; a taken BLE
// reported in the same cycle still redirects (redirect beats stall).
//
// Instruction fields: opcode [27:24], target/dest [23:16], src [15:8]/[7:0],
// NOP immediate [23:0]. Opcode encodings come from the shared definitions
// (`NOP, `JMP, `BLE); fallback values are provided here if not already set.
// -----------------------------------------------------------------------------
`ifndef NOP
`define NOP 4'h0
`endif
`ifndef JMP
`define JMP 4'h8
`endif
`ifndef BLE
`define BLE 4'h9
`endif

module instruction_fetch_unit #(
    parameter logic [15:0] RESET_ADDR = 16'd0,
    parameter int          DELAY_W    = 24
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic [15:0] oAddress,
    input  logic [27:0] iInstruction,
    output logic [27:0] oInstruction,
    output logic        oValid,
    output logic [15:0] oInstrAddr,
    input  logic        iStall,
    input  logic        iBranchTaken,
    input  logic [7:0]  iBranchTarget,
    output logic        oDelayBusy
);

    localparam logic [27:0] NOP_WORD = {`NOP, 24'd0};

    // Architectural registers
    logic [15:0] r_pc;
    logic [27:0] r_instr;
    logic        r_valid;
    logic [15:0] r_iaddr;

    // Next-state values
    logic [15:0] w_pc_nxt;
    logic [27:0] w_instr_nxt;
    logic        w_valid_nxt;
    logic [15:0] w_iaddr_nxt;

    logic        w_branch;
    logic        w_capture;
    logic [3:0]  w_fetch_op;

    assign w_fetch_op = iInstruction[27:24];

    // A redirect needs a valid BLE sitting in the output register.
    assign w_branch = iBranchTaken && r_valid && (r_instr[27:24] == `BLE);

`ifdef FETCH_NOP_DELAY_EN
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DELAY = 1'b1
    } state_t;

    localparam logic [DELAY_W-1:0] CNT_ONE = {{(DELAY_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DELAY_W-1:0] r_count;
    logic [DELAY_W-1:0] w_count_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic [DELAY_W-1:0] w_imm;

    assign w_imm = iInstruction[DELAY_W-1:0];

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_RUN;
            r_count <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign oDelayBusy = r_busy;
`else
    assign oDelayBusy = 1'b0;
`endif

    // Next-state / output logic. w_capture marks an edge that loads the ROM
    // word; JMP/NOP decoding of that word is shared between RUN and the
    // last edge of DELAY so the first post-delay instruction needs no bubble.
    always_comb begin
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_valid_nxt = r_valid;
        w_iaddr_nxt = r_iaddr;
        w_capture   = 1'b0;
`ifdef FETCH_NOP_DELAY_EN
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_busy_nxt  = r_busy;

        if (r_state == ST_DELAY) begin
            // First DELAY edge retires the NOP itself (busy on, valid off);
            // the counter then counts N..1 and the edge seeing 1 fetches,
            // giving exactly N bubble cycles. iStall is ignored here.
            if (!r_busy) begin
                w_busy_nxt  = 1'b1;
                w_valid_nxt = 1'b0;
            end else if (r_count <= CNT_ONE) begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_RUN;
                w_capture   = 1'b1;
            end else begin
                w_count_nxt = r_count - CNT_ONE;
            end
        end else
`endif
        if (w_branch) begin
            // Squash the wrong-path word already fetched behind the BLE.
            w_pc_nxt    = {8'd0, iBranchTarget};
            w_instr_nxt = NOP_WORD;
            w_valid_nxt = 1'b0;
        end else if (!iStall) begin
            w_capture = 1'b1;
        end

        if (w_capture) begin
            w_instr_nxt = iInstruction;
            w_valid_nxt = 1'b1;
            w_iaddr_nxt = r_pc;
            if (w_fetch_op == `JMP) begin
                w_pc_nxt = {8'd0, iInstruction[23:16]};
            end else begin
                w_pc_nxt = r_pc + 16'd1;
`ifdef FETCH_NOP_DELAY_EN
                if ((w_fetch_op == `NOP) && (w_imm != '0)) begin
                    w_state_nxt = ST_DELAY;
                    w_count_nxt = w_imm;
                end
`endif
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_pc    <= RESET_ADDR;
            r_instr <= NOP_WORD;
            r_valid <= 1'b0;
            r_iaddr <= 16'd0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_valid <= w_valid_nxt;
            r_iaddr <= w_iaddr_nxt;
        end
    end

    assign oAddress     = r_pc;
    assign oInstruction = r_instr;
    assign oValid       = r_valid;
    assign oInstrAddr   = r_iaddr;

endmodule
